wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the datapath and register-value width.
REQ-002 SHALL have parameter REG_AW, default 4, meaning the register-address width (16 registers).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  MEM stage presents an instruction.
REQ-006 SHALL have port in_ready  output  1  stage accepts an instruction this cycle.
REQ-007 SHALL have port in_wb_en  input  1  instruction writes a register.
REQ-008 SHALL have port in_mem_r_en  input  1  instruction is a load; result comes from memory response.
REQ-009 SHALL have port in_dest  input  REG_AW  destination register index.
REQ-010 SHALL have port in_alu_res  input  DATA_W  ALU result for non-loads.
REQ-011 SHALL have port mem_rvalid  input  1  load data valid this cycle.
REQ-012 SHALL have port mem_rdata  input  DATA_W  load data.
REQ-013 SHALL have port WB_EN  output  1  register-file write enable.
REQ-014 SHALL have port WB_Dest  output  REG_AW  register-file write index.
REQ-015 SHALL have port WB_Value  output  DATA_W  register-file write data.
REQ-016 SHALL have port retired_count  output  32  count of committed instructions.
REQ-017 SHALL have port spurious_rsp  output  1  sticky flag: mem_rvalid seen outside WAIT.

Function
REQ-018 SHALL implement FSM states IDLE, COMMIT, WAIT.
REQ-019 SHALL accept an instruction on a rising edge when in_valid && in_ready, capturing wb_en, mem_r_en, dest, alu_res.
REQ-020 SHALL drive in_ready = 1 in IDLE and COMMIT, 0 in WAIT (combinational from state).
REQ-021 IDLE/COMMIT: accept of non-load -> COMMIT with value = in_alu_res; accept of load -> WAIT; no accept -> IDLE.
REQ-022 WAIT: mem_rvalid=1 -> COMMIT with value = mem_rdata captured that edge; else remain WAIT indefinitely.
REQ-023 SHALL drive WB_EN = (state==COMMIT) && captured wb_en; WB_Dest/WB_Value from registered dest/value, all combinational from registers.
REQ-024 Non-load latency: accept edge N -> WB_EN high for exactly cycle N..N+1; load latency: one cycle after the mem_rvalid edge.
REQ-025 Back-to-back accepts SHALL produce WB_EN high on consecutive cycles with no bubble.
REQ-026 Load with in_wb_en=0 SHALL still wait for mem_rvalid, then COMMIT with WB_EN=0.
REQ-027 retired_count SHALL increment by 1 on every edge leaving COMMIT state or re-entering it (i.e. once per COMMIT cycle), wrapping 0xFFFFFFFF -> 0.
REQ-028 mem_rvalid=1 while state is IDLE or COMMIT SHALL be ignored for data and SHALL set spurious_rsp, which stays 1 until reset.
REQ-029 WB_Dest=15 SHALL be written like any other index; no special-casing.
REQ-030 Outputs SHALL be stable for the whole COMMIT cycle, since the register file samples on the falling edge.

Reset
REQ-031 On rst=1, state SHALL go IDLE immediately; WB_EN=0, WB_Dest=0, WB_Value=0, retired_count=0, spurious_rsp=0, in_ready=1.
REQ-032 Reset during WAIT SHALL discard the pending load; a later mem_rvalid in IDLE SHALL set spurious_rsp.
REQ-033 Reset during COMMIT SHALL suppress WB_EN asynchronously, before the falling edge if asserted first.

Structure
REQ-034 The state enum, DATA_W and REG_AW defaults SHALL live in the shared cpu package.
REQ-035 The block SHALL be a single module with no sub-modules.

Verification
REQ-036 Accept ALU op dest=3, alu_res=0x0000_00AA -> next cycle WB_EN=1, WB_Dest=3, WB_Value=0xAA, retired_count=1.
REQ-037 Accept load dest=5, mem_rvalid after 4 cycles with 0xDEAD_BEEF -> in_ready=0 for 4 cycles, then WB_EN=1, WB_Value=0xDEADBEEF for one cycle.
REQ-038 Three back-to-back ALU ops dest=1,2,3 -> WB_EN high three consecutive cycles, retired_count=3.
REQ-039 mem_rvalid=1 in IDLE -> spurious_rsp=1, WB_EN stays 0; remains 1 until rst.
REQ-040 rst pulse while WAIT on dest=7 -> IDLE, in_ready=1, no write to 7, retired_count=0.
REQ-041 Preload retired_count near wrap (0xFFFFFFFF via 2^32-1 commits or force) -> next commit yields 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the write-back stage state encoding.
package cpu_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_AW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    WAIT   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_stage.sv
// Write-back stage: takes one instruction from MEM, waits for load data when needed,
// and presents a register-file write for exactly one cycle.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              WB_EN,
  output logic [REG_AW-1:0] WB_Dest,
  output logic [DATA_W-1:0] WB_Value,
  output logic [31:0]       retired_count,
  output logic              spurious_rsp
);

  wb_state_e         state_reg;
  logic              wb_en_reg;
  logic [REG_AW-1:0] dest_reg;
  logic [DATA_W-1:0] value_reg;
  logic [31:0]       count_reg;
  logic              spurious_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      wb_en_reg    <= 1'b0;
      dest_reg     <= '0;
      value_reg    <= '0;
      count_reg    <= '0;
      spurious_reg <= 1'b0;
    end else begin
      // Every cycle spent in COMMIT retires exactly one instruction.
      if (state_reg == COMMIT) begin
        count_reg <= count_reg + 32'd1;
      end
      if (mem_rvalid && (state_reg != WAIT)) begin
        spurious_reg <= 1'b1;
      end

      case (state_reg)
        IDLE, COMMIT: begin
          if (in_valid) begin
            wb_en_reg <= in_wb_en;
            dest_reg  <= in_dest;
            value_reg <= in_alu_res;
            state_reg <= in_mem_r_en ? WAIT : COMMIT;
          end else begin
            state_reg <= IDLE;
          end
        end
        WAIT: begin
          // The ALU value captured on accept is replaced by the load response.
          if (mem_rvalid) begin
            value_reg <= mem_rdata;
            state_reg <= COMMIT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Decoding from state lets an asserted rst drop WB_EN without waiting for a clock.
  assign in_ready      = (state_reg != WAIT);
  assign WB_EN         = (state_reg == COMMIT) && wb_en_reg;
  assign WB_Dest       = dest_reg;
  assign WB_Value      = value_reg;
  assign retired_count = count_reg;
  assign spurious_rsp  = spurious_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected writes are queued at issue and matched by a monitor.
module tb_wb_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  typedef struct {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] value;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_wb_en;
  logic              in_mem_r_en;
  logic [REG_AW-1:0] in_dest;
  logic [DATA_W-1:0] in_alu_res;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              WB_EN;
  logic [REG_AW-1:0] WB_Dest;
  logic [DATA_W-1:0] WB_Value;
  logic [31:0]       retired_count;
  logic              spurious_rsp;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
    .in_dest(in_dest), .in_alu_res(in_alu_res),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .WB_EN(WB_EN), .WB_Dest(WB_Dest), .WB_Value(WB_Value),
    .retired_count(retired_count), .spurious_rsp(spurious_rsp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_wb_en = 1'b0; in_mem_r_en = 1'b0;
    in_dest = '0; in_alu_res = '0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic drive_op(input logic wb, input logic ld, input logic [REG_AW-1:0] d,
                          input logic [DATA_W-1:0] v);
    in_valid = 1'b1; in_wb_en = wb; in_mem_r_en = ld; in_dest = d; in_alu_res = v;
  endtask

  task automatic push_exp(input logic [REG_AW-1:0] d, input logic [DATA_W-1:0] v);
    wr_t w;
    w.dest = d;
    w.value = v;
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every register-file write seen on the falling edge must match the queue head.
  always @(negedge clk) begin
    if (!rst && WB_EN) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: dest=%0d value=0x%08h, none expected", WB_Dest, WB_Value);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_dest", 32'(WB_Dest), 32'(w.dest));
        check("wr_value", WB_Value, w.value);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    check("rst_wb_en", 32'(WB_EN), 32'd0);
    check("rst_dest", 32'(WB_Dest), 32'd0);
    check("rst_value", WB_Value, 32'd0);
    check("rst_count", retired_count, 32'd0);
    check("rst_spurious", 32'(spurious_rsp), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Single ALU op.
    drive_op(1'b1, 1'b0, 4'd3, 32'h0000_00AA);
    push_exp(4'd3, 32'h0000_00AA);
    tick();
    idle_inputs();
    check("alu_wb_en", 32'(WB_EN), 32'd1);
    check("alu_dest", 32'(WB_Dest), 32'd3);
    check("alu_value", WB_Value, 32'h0000_00AA);
    tick();
    check("alu_count", retired_count, 32'd1);
    check("alu_wb_en_drop", 32'(WB_EN), 32'd0);

    // Load answered after four cycles.
    drive_op(1'b1, 1'b1, 4'd5, 32'h1111_1111);
    push_exp(4'd5, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      check("load_in_ready_low", 32'(in_ready), 32'd0);
      check("load_no_wb", 32'(WB_EN), 32'd0);
      if (i == 3) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end
      tick();
    end
    idle_inputs();
    check("load_wb_en", 32'(WB_EN), 32'd1);
    check("load_value", WB_Value, 32'hDEAD_BEEF);
    check("load_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("load_wb_en_drop", 32'(WB_EN), 32'd0);
    check("load_count", retired_count, 32'd2);
    check("load_spurious", 32'(spurious_rsp), 32'd0);

    // Three back-to-back ALU ops.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive_op(1'b1, 1'b0, 4'(k), 32'h100 + 32'(k));
      push_exp(4'(k), 32'h100 + 32'(k));
      tick();
      check("b2b_wb_en", 32'(WB_EN), 32'd1);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
    end
    idle_inputs();
    tick();
    check("b2b_count", retired_count, 32'd3);
    check("b2b_wb_en_drop", 32'(WB_EN), 32'd0);

    // Load without write enable still waits, then commits silently.
    drive_op(1'b0, 1'b1, 4'd9, 32'h0);
    tick();
    idle_inputs();
    check("nowb_waiting", 32'(in_ready), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_1234;
    tick();
    idle_inputs();
    check("nowb_commit_ready", 32'(in_ready), 32'd1);
    check("nowb_wb_en", 32'(WB_EN), 32'd0);
    tick();
    check("nowb_count", retired_count, 32'd4);

    // Register 15 written like any other index.
    drive_op(1'b1, 1'b0, 4'd15, 32'h55AA_55AA);
    push_exp(4'd15, 32'h55AA_55AA);
    tick();
    idle_inputs();
    check("r15_dest", 32'(WB_Dest), 32'd15);
    tick();

    // Stray response in IDLE is flagged and sticky until reset.
    do_reset();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    check("spur_set", 32'(spurious_rsp), 32'd1);
    check("spur_no_wb", 32'(WB_EN), 32'd0);
    tick();
    tick();
    check("spur_sticky", 32'(spurious_rsp), 32'd1);
    check("spur_count", retired_count, 32'd0);
    do_reset();
    check("spur_cleared", 32'(spurious_rsp), 32'd0);

    // Reset while waiting on a load to r7 drops the load.
    drive_op(1'b1, 1'b1, 4'd7, 32'h0);
    tick();
    idle_inputs();
    check("rwait_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rwait_async_ready", 32'(in_ready), 32'd1);
    check("rwait_count", retired_count, 32'd0);
    #1;
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0077;
    tick();
    idle_inputs();
    check("rwait_spurious", 32'(spurious_rsp), 32'd1);
    check("rwait_no_wb", 32'(WB_EN), 32'd0);
    tick();
    check("rwait_count_after", retired_count, 32'd0);

    // Reset during COMMIT kills WB_EN before the falling edge.
    do_reset();
    drive_op(1'b1, 1'b0, 4'd4, 32'h4444_4444);
    tick();
    idle_inputs();
    check("rcommit_wb_en", 32'(WB_EN), 32'd1);
    rst = 1'b1;
    #1;
    check("rcommit_async_drop", 32'(WB_EN), 32'd0);
    tick();
    rst = 1'b0;

    // Counter wraps from all-ones to zero.
    force dut.count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.count_reg;
    check("wrap_preload", retired_count, 32'hFFFF_FFFF);
    tick();
    drive_op(1'b1, 1'b0, 4'd2, 32'h0000_0002);
    push_exp(4'd2, 32'h0000_0002);
    tick();
    idle_inputs();
    check("wrap_pre_commit", retired_count, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", retired_count, 32'd0);

    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
